// File: rtl/omsp_spm_cmd_seq_if.sv
// Signal bundle between the SPM command sequencer (master) and its environment:
// execution unit, SPM control block and key-derivation engine (slave).
interface omsp_spm_cmd_seq_if #(
  parameter int KEY_IDX_SIZE = 3
);
  logic                    cmd_valid;
  logic                    cmd_enable;
  logic                    cmd_ready;
  logic                    update_spm;
  logic                    enable_spm;
  logic                    violation;
  logic                    kw_valid;
  logic [15:0]             kw_data;
  logic                    kw_ready;
  logic                    write_key;
  logic [15:0]             key_in;
  logic [KEY_IDX_SIZE-1:0] key_idx;
  logic                    busy;
  logic                    done;
  logic                    fail;
  logic [1:0]              seq_state;

  modport master (
    input  cmd_valid, cmd_enable, violation, kw_valid, kw_data,
    output cmd_ready, update_spm, enable_spm, kw_ready, write_key, key_in, key_idx,
           busy, done, fail, seq_state
  );

  modport slave (
    output cmd_valid, cmd_enable, violation, kw_valid, kw_data,
    input  cmd_ready, update_spm, enable_spm, kw_ready, write_key, key_in, key_idx,
           busy, done, fail, seq_state
  );
endinterface

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: issues protect/unprotect updates and streams the module key.
// Optional SPM_KEY_TIMEOUT_EN aborts a protect after 255 idle key cycles.
module omsp_spm_cmd_seq #(
  parameter int KEY_IDX_SIZE = 3,
  parameter int KEY_WORDS    = 8
) (
  input  logic                  mclk,
  input  logic                  puc_rst,
  omsp_spm_cmd_seq_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_KEY    = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t                  state;
  logic [KEY_IDX_SIZE-1:0] word_cnt;
  logic                    en_lat;
  logic                    cmd_ready_r;
  logic                    update_r;
  logic                    kw_ready_r;
  logic                    done_r;
  logic                    fail_r;
  logic                    key_last;

  assign key_last = (word_cnt == KEY_IDX_SIZE'(KEY_WORDS - 1));

`ifdef SPM_KEY_TIMEOUT_EN
  logic [7:0] idle_cnt;
`endif

  // Handshakes: a command transfers on a cycle with cmd_valid=1 and cmd_ready=1;
  // a key word transfers on a cycle with kw_valid=1 and kw_ready=1, and that same
  // cycle is the write_key strobe into the SPM array. Neither side may retract.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      en_lat      <= 1'b0;
      cmd_ready_r <= 1'b1;
      update_r    <= 1'b0;
      kw_ready_r  <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
`ifdef SPM_KEY_TIMEOUT_EN
      idle_cnt    <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            en_lat      <= bus.cmd_enable;
            cmd_ready_r <= 1'b0;
            update_r    <= 1'b1;
            state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          update_r <= 1'b0;
          if (bus.violation) begin
            done_r <= 1'b1;
            fail_r <= 1'b1;
            state  <= S_FIN;
          end else if (en_lat) begin
            word_cnt   <= '0;
            kw_ready_r <= 1'b1;
            state      <= S_KEY;
`ifdef SPM_KEY_TIMEOUT_EN
            idle_cnt   <= 8'd0;
`endif
          end else begin
            done_r <= 1'b1;
            fail_r <= 1'b0;
            state  <= S_FIN;
          end
        end
        S_KEY: begin
          if (bus.kw_valid) begin
`ifdef SPM_KEY_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
            if (key_last) begin
              kw_ready_r <= 1'b0;
              done_r     <= 1'b1;
              fail_r     <= 1'b0;
              state      <= S_FIN;
            end else begin
              word_cnt <= word_cnt + KEY_IDX_SIZE'(1);
            end
          end
`ifdef SPM_KEY_TIMEOUT_EN
          // Abort at the edge where the idle count would reach 255; written words stay.
          else if (idle_cnt == 8'd254) begin
            idle_cnt   <= 8'd255;
            kw_ready_r <= 1'b0;
            done_r     <= 1'b1;
            fail_r     <= 1'b1;
            state      <= S_FIN;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
`endif
        end
        S_FIN: begin
          done_r      <= 1'b0;
          fail_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // kw_ready_r is high exactly while in KEY, so it gates the key-side outputs.
  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.busy       = ~cmd_ready_r;
  assign bus.update_spm = update_r;
  assign bus.enable_spm = update_r & en_lat;
  assign bus.kw_ready   = kw_ready_r;
  assign bus.write_key  = kw_ready_r & bus.kw_valid;
  assign bus.key_in     = kw_ready_r ? bus.kw_data : 16'h0000;
  assign bus.key_idx    = kw_ready_r ? word_cnt : '0;
  assign bus.done       = done_r;
  assign bus.fail       = fail_r;
  assign bus.seq_state  = state;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Randomized bench for omsp_spm_cmd_seq: a cycle-timeline model of each command
// (accept, update, key stream, finish) with an expected key-word queue.
module tb_omsp_spm_cmd_seq;
  localparam int KEY_IDX_SIZE = 3;
  localparam int KEY_WORDS    = 8;
  localparam int W            = KEY_IDX_SIZE + 16;
  localparam int KEY_BUDGET   = 600;

  logic mclk = 1'b0;
  logic puc_rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] exp_q[$];

  omsp_spm_cmd_seq_if #(.KEY_IDX_SIZE(KEY_IDX_SIZE)) bus ();

  omsp_spm_cmd_seq #(
    .KEY_IDX_SIZE(KEY_IDX_SIZE),
    .KEY_WORDS   (KEY_WORDS)
  ) dut (
    .mclk   (mclk),
    .puc_rst(puc_rst),
    .bus    (bus.master)
  );

  // Clock / reset
  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_update"},    32'(bus.update_spm), 0);
    check({tag, "_enable"},    32'(bus.enable_spm), 0);
    check({tag, "_kw_ready"},  32'(bus.kw_ready), 0);
    check({tag, "_write_key"}, 32'(bus.write_key), 0);
    check({tag, "_key_in"},    32'(bus.key_in), 0);
    check({tag, "_key_idx"},   32'(bus.key_idx), 0);
    check({tag, "_done"},      32'(bus.done), 0);
    check({tag, "_fail"},      32'(bus.fail), 0);
  endtask

  // Driver: one full command. p_valid is the kw_valid percentage in KEY;
  // stall_after>=0 forces kw_valid low once that many words were delivered.
  task automatic run_cmd(input bit en, input bit viol, input int p_valid,
                         input int stall_after, input bit seq_data);
    bit v;
    bit timed_out;
    bit exp_fail;
    int idle;
    int k;
    logic [W-1:0] w;
    exp_q.delete();
    for (int i = 0; i < KEY_WORDS; i++)
      exp_q.push_back({KEY_IDX_SIZE'(i), seq_data ? 16'(16'h1000 + i) : 16'($urandom)});

    // Accept cycle
    @(negedge mclk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_enable = en;
    bus.violation  = 1'($urandom_range(0, 1));
    bus.kw_valid   = 1'($urandom_range(0, 1));
    bus.kw_data    = 16'($urandom);
    #1;
    check("accept_ready", 32'(bus.cmd_ready), 1);
    check("accept_wkey",  32'(bus.write_key), 0);
    check("accept_upd",   32'(bus.update_spm), 0);

    // Update cycle: cmd_valid here must be ignored
    @(negedge mclk);
    bus.cmd_valid  = 1'($urandom_range(0, 1));
    bus.cmd_enable = 1'($urandom_range(0, 1));
    bus.violation  = viol;
    bus.kw_valid   = 1'($urandom_range(0, 1));
    bus.kw_data    = 16'($urandom);
    #1;
    check("upd_update", 32'(bus.update_spm), 1);
    check("upd_enable", 32'(bus.enable_spm), 32'(en));
    check("upd_ready",  32'(bus.cmd_ready), 0);
    check("upd_busy",   32'(bus.busy), 1);
    check("upd_kwrdy",  32'(bus.kw_ready), 0);
    check("upd_wkey",   32'(bus.write_key), 0);
    check("upd_done",   32'(bus.done), 0);

    exp_fail  = viol;
    timed_out = 1'b0;
    idle      = 0;
    k         = 0;
    if (en && !viol) begin
      while (exp_q.size() != 0 && !timed_out && k < KEY_BUDGET) begin
        k++;
        @(negedge mclk);
        v = ($urandom_range(1, 100) <= p_valid) &&
            !(stall_after >= 0 && (KEY_WORDS - exp_q.size()) >= stall_after);
        bus.kw_valid   = v;
        bus.kw_data    = v ? exp_q[0][15:0] : 16'($urandom);
        bus.cmd_valid  = 1'($urandom_range(0, 1));
        bus.cmd_enable = 1'($urandom_range(0, 1));
        bus.violation  = 1'($urandom_range(0, 1));
        #1;
        check("key_kwrdy", 32'(bus.kw_ready), 1);
        check("key_wkey",  32'(bus.write_key), 32'(v));
        check("key_ready", 32'(bus.cmd_ready), 0);
        check("key_upd",   32'(bus.update_spm), 0);
        check("key_done",  32'(bus.done), 0);
        if (v) begin
          w = exp_q.pop_front();
          check("key_word", 32'({bus.key_idx, bus.key_in}), 32'(w));
          idle = 0;
        end else begin
          idle++;
        end
`ifdef SPM_KEY_TIMEOUT_EN
        if (idle == 255) begin
          timed_out = 1'b1;
          exp_fail  = 1'b1;
        end
`endif
      end
      if (k >= KEY_BUDGET) check("key_budget", 32'(k), 0);
    end

    // Finish cycle
    @(negedge mclk);
    bus.cmd_valid = 1'b0;
    bus.kw_valid  = 1'($urandom_range(0, 1));
    bus.violation = 1'($urandom_range(0, 1));
    bus.kw_data   = 16'($urandom);
    #1;
    check("fin_done",  32'(bus.done), 1);
    check("fin_fail",  32'(bus.fail), 32'(exp_fail));
    check("fin_ready", 32'(bus.cmd_ready), 0);
    check("fin_upd",   32'(bus.update_spm), 0);
    check("fin_kwrdy", 32'(bus.kw_ready), 0);
    check("fin_wkey",  32'(bus.write_key), 0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      bus.cmd_valid = 1'b0;
      bus.kw_valid  = 1'($urandom_range(0, 1));
      bus.violation = 1'($urandom_range(0, 1));
      bus.kw_data   = 16'($urandom);
      #1;
      check_idle("gap");
    end
  endtask

  // Protect aborted by reset after three delivered key words.
  task automatic reset_mid_key();
    @(negedge mclk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_enable = 1'b1;
    bus.violation  = 1'b0;
    bus.kw_valid   = 1'b0;
    @(negedge mclk);
    bus.cmd_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      bus.kw_valid = 1'b1;
      bus.kw_data  = 16'(16'h2000 + i);
      #1;
      check("rst_pre_wkey", 32'(bus.write_key), 1);
      check("rst_pre_idx",  32'(bus.key_idx), 32'(i));
    end
    @(negedge mclk);
    bus.kw_valid = 1'b1;
    #1 puc_rst = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge mclk);
    puc_rst      = 1'b0;
    bus.kw_valid = 1'b0;
    #1;
    check_idle("rst_release");
  endtask

  initial begin
    puc_rst        = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_enable = 1'b0;
    bus.violation  = 1'b0;
    bus.kw_valid   = 1'b0;
    bus.kw_data    = 16'h0000;
    repeat (3) @(negedge mclk);
    #1;
    check_idle("in_reset");
    @(negedge mclk);
    puc_rst = 1'b0;
    #1;
    check_idle("post_reset");

    run_cmd(1'b1, 1'b0, 100, -1, 1'b1);   // protect, streamed words 1000..1007
    idle_gap(2);
    run_cmd(1'b1, 1'b1, 100, -1, 1'b0);   // protect rejected by violation
    idle_gap(1);
    run_cmd(1'b0, 1'b0, 100, -1, 1'b0);   // unprotect
    run_cmd(1'b0, 1'b1, 100, -1, 1'b0);   // unprotect rejected
    run_cmd(1'b1, 1'b0, 40, -1, 1'b0);    // protect with stalled key source
    reset_mid_key();
    run_cmd(1'b1, 1'b0, 100, -1, 1'b1);   // restart must begin at key_idx 0

    for (int n = 0; n < 30; n++) begin
      run_cmd(1'($urandom_range(0, 1)), ($urandom_range(1, 4) == 1),
              $urandom_range(30, 100), -1, 1'b0);
      idle_gap($urandom_range(0, 3));
    end

`ifdef SPM_KEY_TIMEOUT_EN
    run_cmd(1'b1, 1'b0, 100, 2, 1'b0);    // two words then 255 idle cycles
    idle_gap(1);
    run_cmd(1'b1, 1'b0, 100, -1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
